mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits; hi and lo are each WIDTH bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: mult_start  input  1  pulse that requests signed multiply of a*b.
REQ-005 Port: div_start  input  1  pulse that requests signed divide of a/b.
REQ-006 Port: a  input  WIDTH  operand rs (multiplicand / dividend).
REQ-007 Port: b  input  WIDTH  operand rt (multiplier / divisor).
REQ-008 Port: hi  output  WIDTH  HI register (product upper half / remainder), consumed by the write-data mux for mfhi.
REQ-009 Port: lo  output  WIDTH  LO register (product lower half / quotient), consumed by the write-data mux for mflo.
REQ-010 Port: busy  output  1  high while an operation is in progress.
REQ-011 Port: done  output  1  one-cycle pulse when hi/lo hold the new result.
REQ-012 Port: div_zero  output  1  high with done when the completed divide had b==0; held until the next start.

Function
REQ-013 FSM states SHALL be: IDLE, MULT, DIV, FIX, DONE.
REQ-014 In IDLE, mult_start SHALL capture a and b, register operand magnitudes and result sign, and enter MULT with iteration counter = WIDTH.
REQ-015 In IDLE, div_start with b!=0 SHALL capture operands and enter DIV; with b==0 it SHALL enter DONE directly.
REQ-016 mult_start and div_start both high in IDLE -> multiply wins; div_start ignored.
REQ-017 Starts while busy SHALL be ignored, with no effect on state, operands or hi/lo.
REQ-018 MULT SHALL perform one unsigned shift-add step per cycle; DIV SHALL perform one restoring subtract-shift step per cycle; each SHALL leave after exactly WIDTH cycles and enter FIX.
REQ-019 FIX SHALL apply signs: product negated when the operand signs differ; quotient negated when the signs differ; remainder takes the dividend's sign (truncation toward zero).
REQ-020 DONE SHALL load hi/lo, assert done for exactly one cycle, and return to IDLE.
REQ-021 Latency, start cycle to done high: WIDTH+2 cycles for mult and nonzero div; 1 cycle for divide-by-zero.
REQ-022 Divide by zero SHALL set hi=a, lo=all ones, div_zero=1.
REQ-023 busy SHALL be high in MULT, DIV, FIX and DONE, and low in IDLE.
REQ-024 hi/lo SHALL change only in DONE and SHALL otherwise hold their last result, including during a new operation.
REQ-025 Operand changes after the start cycle SHALL NOT affect the result.
REQ-026 Most-negative dividend / -1 SHALL yield lo=most-negative and hi=0 (wraps, no trap).

Reset
REQ-027 reset low SHALL immediately force IDLE and set hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0.
REQ-028 reset asserted mid-operation SHALL abort the operation; no done is issued afterwards.
REQ-029 After reset release, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-030 Macro MULT_DIV_UNIT_DIV_EN defined: divide path (DIV state, div_start, div_zero) SHALL be fully functional.
REQ-031 Macro undefined: the divider logic SHALL be absent, div_start SHALL be ignored, div_zero SHALL be tied 0, and multiply behaviour SHALL be unchanged.

Structure
REQ-032 Package mult_div_pkg SHALL hold the FSM state enum, the default WIDTH constant, and the divide-by-zero LO constant (all ones).
REQ-033 One combinational sub-module div_step (single restoring-division iteration: partial remainder, divisor -> next remainder, quotient bit) SHALL be instantiated, only under MULT_DIV_UNIT_DIV_EN.

Verification
REQ-034 mult_start, a=7, b=-3 -> done after 34 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy high 34 cycles.
REQ-035 div_start, a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), div_zero=0.
REQ-036 div_start, a=5, b=0 -> done next cycle, hi=5, lo=0xFFFFFFFF, div_zero=1.
REQ-037 mult_start and div_start together, a=0x10000, b=0x10000 -> multiply executed, hi=1, lo=0; a second mult_start mid-operation is ignored.
REQ-038 reset low at cycle 10 of a multiply -> outputs zero immediately, no done pulse afterwards; a fresh mult 3*4 -> lo=12.
REQ-039 Build without MULT_DIV_UNIT_DIV_EN: div_start, a=9, b=3 -> busy stays 0, hi/lo unchanged, no done.

Source files
------------

// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - shared types and constants for the multiply/divide unit
// Holds the FSM state encoding, the default operand width and the LO value
// returned by a divide by zero.
package mult_div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Truncated to WIDTH at the point of use; wide enough for WIDTH <= 64.
    localparam logic [63:0] DIV_ZERO_LO = '1;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result bundle between issuer and multiply/divide unit
// Signals:
//   mult_start, div_start : start pulses from the issuer
//   a, b                  : operands (multiplicand/dividend, multiplier/divisor)
//   hi, lo                : HI/LO result registers
//   busy, done, div_zero  : status from the unit
// Modports: master (issuer side), slave (unit side).
interface mult_div_unit_if import mult_div_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             mult_start;
    logic             div_start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output mult_start, div_start, a, b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  mult_start, div_start, a, b,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_unit_div_step.sv
// rtl/mult_div_unit_div_step.sv - one restoring-division iteration (combinational)
// Ports:
//   partial  : shifted partial remainder (WIDTH+1 bits)
//   divisor  : divisor magnitude
//   rem_next : remainder after the trial subtraction (restored if negative)
//   q_bit    : quotient bit produced by this iteration
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   partial,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    logic [WIDTH:0] diff;

    // partial < 2*divisor, so the difference always fits in WIDTH+1 bits and
    // its top bit is a reliable sign.
    always_comb begin
        diff     = partial - {1'b0, divisor};
        q_bit    = ~diff[WIDTH];
        rem_next = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    end
endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed multiply / divide unit with HI/LO registers
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : mult_div_unit_if.slave (starts, operands, hi/lo, busy/done/div_zero)
// Config macro: MULT_DIV_UNIT_DIV_EN enables the divide path; without it only
// multiply is implemented and div_zero is tied low.
// Multiply: WIDTH unsigned shift-add steps on operand magnitudes, then sign fix.
// Divide:   WIDTH restoring steps on magnitudes, then sign fix (truncating).
module mult_div_unit import mult_div_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits / quotient bits}.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               neg_res;
    logic [WIDTH:0]     mul_sum;
    logic               last_step;

`ifdef MULT_DIV_UNIT_DIV_EN
    logic               neg_rem;
    logic               op_div;
    logic               div_zero_r;
    logic [WIDTH-1:0]   rem_next;
    logic               q_bit;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .partial  ({acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]}),
        .divisor  (mcand),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );
`endif

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        // The most negative value maps to itself, which is correct as unsigned.
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    assign last_step = (cnt == CNT_W'(1));
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.mult_start) begin
                    state_next = MULT;
                end
`ifdef MULT_DIV_UNIT_DIV_EN
                else if (bus.div_start) begin
                    state_next = (bus.b == '0) ? DONE : DIV;
                end
`endif
            end
            MULT:    if (last_step) state_next = FIX;
            DIV:     if (last_step) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != IDLE);
        bus.done = (state == DONE);
    end

    assign bus.hi = hi_r;
    assign bus.lo = lo_r;
`ifdef MULT_DIV_UNIT_DIV_EN
    assign bus.div_zero = div_zero_r;
`else
    assign bus.div_zero = 1'b0;
`endif

    // hi/lo are written only on the edges that enter DONE (from FIX, or
    // straight from IDLE for a divide by zero).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            acc        <= '0;
            mcand      <= '0;
            neg_res    <= 1'b0;
            hi_r       <= '0;
            lo_r       <= '0;
`ifdef MULT_DIV_UNIT_DIV_EN
            neg_rem    <= 1'b0;
            op_div     <= 1'b0;
            div_zero_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mult_start) begin
                        mcand      <= magnitude(bus.a);
                        acc        <= {{WIDTH{1'b0}}, magnitude(bus.b)};
                        neg_res    <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        cnt        <= CNT_W'(WIDTH);
`ifdef MULT_DIV_UNIT_DIV_EN
                        op_div     <= 1'b0;
                        div_zero_r <= 1'b0;
`endif
                    end
`ifdef MULT_DIV_UNIT_DIV_EN
                    else if (bus.div_start) begin
                        if (bus.b == '0) begin
                            hi_r       <= bus.a;
                            lo_r       <= WIDTH'(DIV_ZERO_LO);
                            div_zero_r <= 1'b1;
                        end else begin
                            mcand      <= magnitude(bus.b);
                            acc        <= {{WIDTH{1'b0}}, magnitude(bus.a)};
                            neg_res    <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                            neg_rem    <= bus.a[WIDTH-1];
                            cnt        <= CNT_W'(WIDTH);
                            op_div     <= 1'b1;
                            div_zero_r <= 1'b0;
                        end
                    end
`endif
                end
                MULT: begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                    cnt <= cnt - CNT_W'(1);
                end
`ifdef MULT_DIV_UNIT_DIV_EN
                DIV: begin
                    acc <= {rem_next, acc[WIDTH-2:0], q_bit};
                    cnt <= cnt - CNT_W'(1);
                end
`endif
                FIX: begin
`ifdef MULT_DIV_UNIT_DIV_EN
                    if (op_div) begin
                        lo_r <= neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                        hi_r <= neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                    end else
`endif
                    begin
                        {hi_r, lo_r} <= neg_res ? -acc : acc;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit (behavioural model + directed vectors)
module tb_mult_div_unit;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mult_div_unit_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: a countdown to the done cycle plus the arithmetic result.
    int           m_left = 0;
    logic [W-1:0] m_hi   = '0;
    logic [W-1:0] m_lo   = '0;
    logic [W-1:0] p_hi   = '0;
    logic [W-1:0] p_lo   = '0;
    logic         m_dz   = 1'b0;

    function automatic logic [63:0] smul(input logic [W-1:0] x, input logic [W-1:0] y);
        longint lx, ly;
        lx = longint'($signed(x));
        ly = longint'($signed(y));
        return 64'(lx * ly);
    endfunction

    function automatic logic [63:0] sdiv(input logic [W-1:0] x, input logic [W-1:0] y);
        longint lx, ly, q, r;
        lx = longint'($signed(x));
        ly = longint'($signed(y));
        q  = lx / ly;
        r  = lx % ly;
        return {r[31:0], q[31:0]};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_dz   <= 1'b0;
        end else if (m_left == 0) begin
            if (bus.mult_start) begin
                p_hi   <= smul(bus.a, bus.b) >> 32;
                p_lo   <= 32'(smul(bus.a, bus.b));
                m_left <= W + 2;
                m_dz   <= 1'b0;
            end
`ifdef MULT_DIV_UNIT_DIV_EN
            else if (bus.div_start) begin
                if (bus.b == '0) begin
                    m_hi   <= bus.a;
                    m_lo   <= '1;
                    m_dz   <= 1'b1;
                    m_left <= 1;
                end else begin
                    p_hi   <= sdiv(bus.a, bus.b) >> 32;
                    p_lo   <= 32'(sdiv(bus.a, bus.b));
                    m_left <= W + 2;
                    m_dz   <= 1'b0;
                end
            end
`endif
        end else begin
            if (m_left == 2) begin
                m_hi <= p_hi;
                m_lo <= p_lo;
            end
            m_left <= m_left - 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("cyc_busy", bus.busy, m_left != 0);
        check("cyc_done", bus.done, m_left == 1);
        check("cyc_hi", bus.hi, m_hi);
        check("cyc_lo", bus.lo, m_lo);
        check("cyc_dz", bus.div_zero, m_dz);
    end

    // Issues one start, scrambles operands afterwards, optionally pokes a
    // second start at cycle 'poke', and checks latency/busy/result on done.
    task automatic run_op(input string name, input logic ms, input logic ds,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input int lat, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input logic edz, input int poke);
        int   n;
        int   busy_n;
        logic seen;
        bus.mult_start = ms;
        bus.div_start  = ds;
        bus.a          = a;
        bus.b          = b;
        @(negedge clk);
        bus.mult_start = 1'b0;
        bus.div_start  = 1'b0;
        bus.a          = $urandom;
        bus.b          = $urandom;
        n      = 1;
        busy_n = 0;
        seen   = 1'b0;
        while (n < 80 && !seen) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (n == poke) begin
                    bus.mult_start = 1'b1;
                    bus.div_start  = 1'b1;
                end
                @(negedge clk);
                bus.mult_start = 1'b0;
                bus.div_start  = 1'b0;
                n++;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: no done within %0d cycles, want %0d", name, n, lat);
        end else begin
            check({name, "_lat"}, n, lat);
            check({name, "_busy_cycles"}, busy_n, lat);
            check({name, "_hi"}, bus.hi, ehi);
            check({name, "_lo"}, bus.lo, elo);
            check({name, "_dz"}, bus.div_zero, edz);
        end
        @(negedge clk);
        check({name, "_idle_after"}, bus.busy, 1'b0);
    endtask

    initial begin
        int busy_seen;
        int done_seen;
        bus.mult_start = 1'b0;
        bus.div_start  = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        #3 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);
        check("rst_dz", bus.div_zero, 1'b0);

        // Start presented together with reset release: first edge accepts it.
        #2 reset = 1'b1;
        run_op("mul_7_m3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 34,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0);
        check("model_mul_hi", m_hi, 32'hFFFF_FFFF);
        check("model_mul_lo", m_lo, 32'hFFFF_FFEB);

        run_op("both_starts", 1'b1, 1'b1, 32'h0001_0000, 32'h0001_0000, 34,
               32'h1, 32'h0, 1'b0, 10);
        run_op("mul_min_min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 34,
               32'h4000_0000, 32'h0, 1'b0, 0);
        run_op("mul_m1_m1", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34,
               32'h0, 32'h1, 1'b0, 0);
        run_op("mul_ffff", 1'b1, 1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 34,
               32'h0, 32'hFFFE_0001, 1'b0, 0);

`ifdef MULT_DIV_UNIT_DIV_EN
        run_op("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 34,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
        check("model_div_lo", m_lo, 32'hFFFF_FFFD);
        run_op("div_5_0", 1'b0, 1'b1, 32'd5, 32'd0, 1,
               32'd5, 32'hFFFF_FFFF, 1'b1, 0);
        repeat (3) @(negedge clk);
        check("dz_held", bus.div_zero, 1'b1);
        check("model_dz_held", m_dz, 1'b1);
        run_op("div_min_m1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34,
               32'h0, 32'h8000_0000, 1'b0, 0);
        run_op("div_100_m7", 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 34,
               32'd2, 32'hFFFF_FFF2, 1'b0, 0);
        run_op("div_m100_7", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 34,
               32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, 0);
        run_op("div_9_3", 1'b0, 1'b1, 32'd9, 32'd3, 34,
               32'd0, 32'd3, 1'b0, 0);
`else
        bus.div_start = 1'b1;
        bus.a         = 32'd9;
        bus.b         = 32'd3;
        @(negedge clk);
        bus.div_start = 1'b0;
        busy_seen = 0;
        done_seen = 0;
        repeat (40) begin
            if (bus.busy) busy_seen++;
            if (bus.done) done_seen++;
            @(negedge clk);
        end
        check("nodiv_busy", busy_seen, 0);
        check("nodiv_done", done_seen, 0);
        check("nodiv_hi", bus.hi, 32'h0);
        check("nodiv_lo", bus.lo, 32'hFFFE_0001);
        check("nodiv_dz", bus.div_zero, 1'b0);
`endif

        // Reset in the middle of a multiply.
        bus.mult_start = 1'b1;
        bus.a          = 32'h1234;
        bus.b          = 32'h5678;
        @(negedge clk);
        bus.mult_start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_done", bus.done, 1'b0);
        check("midrst_hi", bus.hi, 32'h0);
        check("midrst_lo", bus.lo, 32'h0);
        check("midrst_dz", bus.div_zero, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        done_seen = 0;
        repeat (45) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check("midrst_no_done", done_seen, 0);
        run_op("mul_3_4", 1'b1, 1'b0, 32'd3, 32'd4, 34,
               32'd0, 32'd12, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
